mdu_sequencer: RTL
==================

// Module: mdu_sequencer
// PURPOSE
//  Multicycle controller plus iterative datapath for multiply/divide instructions (Op=2'b11) that the decoder flags.
//  Runs MUL/MLA and UMULL/SMULL/UMLAL/SMLAL as a 32-step shift-add, and UDIV/SDIV as a 32-step restoring divide.
//  Stalls fetch/decode while busy and writes results through the single register-file write port: lo word, then hi word.
// PARAMETERS
//  XLEN   32  operand width; iteration count equals XLEN
//  RAW    4   register address width
// PORTS
//  clk       in   1       sole clock, rising edge
//  reset     in   1       synchronous, active-low; sampled on rising clk
//  start     in   1       request; sampled only in IDLE
//  op        in   2       00 MUL, 01 MLA (accumulate), 10 DIV, 11 reserved (treated as MUL)
//  is_long   in   1       64-bit result: mul hi word / div remainder written to rd_hi
//  is_signed in   1       two's-complement operands
//  opa       in   XLEN    multiplicand / dividend
//  opb       in   XLEN    multiplier / divisor
//  acc       in   2*XLEN  accumulate addend; hi half ignored unless is_long
//  rd_lo     in   RAW     destination of lo word / quotient
//  rd_hi     in   RAW     destination of hi word / remainder
//  stall     out  1       = start | busy (combinational); freezes PC and IF/ID
//  busy      out  1       state != IDLE
//  we        out  1       register-file write enable
//  wa        out  RAW     write address
//  wd        out  XLEN    write data
//  done      out  1       one-cycle pulse on the final write cycle
//  div_zero  out  1       sticky until next accepted start; set on DIV with opb==0
// BEHAVIOUR
//  - Reset (reset==0 at an edge): state=IDLE, count=0, busy/we/done/div_zero=0, wa=0, wd=0; in-flight op aborted with no write.
//  - Operands, op, flags and rd_* are latched at acceptance; later input changes have no effect.
//  - FSM: IDLE -start-> PREP -> ITER (XLEN cycles, count 0..XLEN-1) -> FIX -> WB_LO -> [WB_HI if is_long] -> IDLE.
//  - PREP: latch magnitudes |opa|, |opb| when signed; record result sign (mul: a^b; quotient: a^b; remainder: a).
//  - ITER mul: if mplier[0], add mcand into prod[2X-1:X]; shift right one, carry included. ITER div: shift rem:quot left; subtract divisor; restore on borrow; set quotient bit otherwise.
//  - FIX: conditional negate (64-bit for mul, each word for div), then add acc when op==MLA; sum wraps mod 2^(2X).
//    For non-long MLA only the low XLEN bits of acc take part.
//  - DIV with opb==0: PREP goes straight to WB_LO and sets div_zero; quotient=all-ones, remainder=opa unmodified.
//  - Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0, no flag.
//  - Latency from the start cycle (cycle 0): WB_LO at cycle XLEN+3 (35), WB_HI at 36; div-by-zero WB_LO at cycle 2.
//  - we=1 only in WB_LO/WB_HI; wa=rd_lo/rd_hi respectively. done=1 in the last WB state.
//  - start while busy is ignored, with no queueing. A new start is accepted in the cycle IDLE is re-entered.
//  - rd_lo==rd_hi: both writes issue in order, so the hi word wins.
// CONFIGURATION
//  MDU_DIV_EN defined: divide path, div_zero logic and op=10 handling are built.
//  MDU_DIV_EN undefined: no divider hardware. op=10 is accepted, takes PREP->WB_LO only and writes 0 to rd_lo, never rd_hi;
//    div_zero is tied 0.
// STRUCTURE
//  mdu_pkg: state enum (IDLE,PREP,ITER,FIX,WB_LO,WB_HI), op codes MDU_MUL/MDU_MLA/MDU_DIV, XLEN default.
//  Sub-module mdu_datapath: holds the 2*XLEN product/remainder register, adder/subtractor and negate logic.
//    It is driven by the FSM through step/load/fix strobes. The FSM, counter and write-port muxing stay in mdu_sequencer.
// TESTING
//  1. UMULL opa=0xFFFFFFFF, opb=0xFFFFFFFF, rd_lo=2, rd_hi=3
//     -> cycle 35 we wa=2 wd=0x00000001; cycle 36 wa=3 wd=0xFFFFFFFE; done at 36.
//  2. SMLAL opa=-3, opb=7, acc=0x0000000000000010 -> lo=0xFFFFFFFB, hi=0xFFFFFFFF.
//  3. MUL (not long) opa=0x10000, opb=0x10000 -> a single write of 0x00000000 at cycle 35; no write at 36; stall low at 36.
//  4. SDIV -7/2, is_long -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//     DIV 5/0 -> wd=0xFFFFFFFF at cycle 2, div_zero=1.
//  5. reset driven low at cycle 20 of an op -> next edge: busy=0, we=0, with no write ever issued.
//     A start held during busy causes no second op.
//  6. Back-to-back: start held high -> second op accepted at the IDLE re-entry cycle. Both results are correct.
//     Without MDU_DIV_EN, op=10 writes 0 at cycle 2.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// The divide path is built only when MDU_DIV_EN is defined.
package mdu_pkg;

    localparam int MDU_XLEN = 32;
    localparam int MDU_RAW  = 4;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        WB_LO,
        WB_HI
    } state_t;

    localparam logic [1:0] MDU_MUL = 2'b00;
    localparam logic [1:0] MDU_MLA = 2'b01;
    localparam logic [1:0] MDU_DIV = 2'b10;

endpackage

// File: rtl/mdu_datapath.sv
// Product/remainder register with shift-add, restoring-subtract and sign fix-up.
// Divider logic exists only when MDU_DIV_EN is defined.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              load,
    input  logic              step,
    input  logic              fix,
    input  logic              is_div,
    input  logic              is_mla,
    input  logic              is_long,
    input  logic              is_signed,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    input  logic [2*XLEN-1:0] acc,
`ifdef MDU_DIV_EN
    output logic              b_zero,
`endif
    output logic [XLEN-1:0]   fix_lo,
    output logic [XLEN-1:0]   res_hi
);

    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] prod;
    logic              neg_lo;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] acc_eff;
    logic [2*XLEN-1:0] fix_val;

    function automatic logic [XLEN-1:0] neg1(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg2(input logic [2*XLEN-1:0] v);
        return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? neg1(v) : v;
    endfunction

    assign add_sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, opnd};

`ifdef MDU_DIV_EN
    logic          neg_hi;
    logic [XLEN:0] sub_diff;

    assign b_zero   = (b_r == '0);
    // Remainder is shifted left before the trial subtract, so it needs one extra bit.
    assign sub_diff = prod[2*XLEN-1:XLEN-1] - {1'b0, opnd};
`endif

    always_comb begin
        prod_s  = neg_lo ? neg2(prod) : prod;
        acc_eff = is_long ? acc_r : {{XLEN{1'b0}}, acc_r[XLEN-1:0]};
        fix_val = prod_s + (is_mla ? acc_eff : {(2*XLEN){1'b0}});
`ifdef MDU_DIV_EN
        if (is_div) begin
            fix_val = {neg_hi ? neg1(prod[2*XLEN-1:XLEN]) : prod[2*XLEN-1:XLEN],
                       neg_lo ? neg1(prod[XLEN-1:0])      : prod[XLEN-1:0]};
        end
`endif
    end

    assign fix_lo = fix_val[XLEN-1:0];
    assign res_hi = prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_r    <= '0;
            b_r    <= '0;
            acc_r  <= '0;
            opnd   <= '0;
            prod   <= '0;
            neg_lo <= 1'b0;
`ifdef MDU_DIV_EN
            neg_hi <= 1'b0;
`endif
        end else begin
            if (capture) begin
                a_r   <= opa;
                b_r   <= opb;
                acc_r <= acc;
            end
            if (load) begin
                if (is_div) begin
`ifdef MDU_DIV_EN
                    opnd   <= mag(b_r, is_signed);
                    neg_lo <= is_signed & (a_r[XLEN-1] ^ b_r[XLEN-1]);
                    neg_hi <= is_signed & a_r[XLEN-1];
                    // Zero divisor skips the iterations: quotient all-ones, remainder raw dividend.
                    prod   <= b_zero ? {a_r, {XLEN{1'b1}}}
                                     : {{XLEN{1'b0}}, mag(a_r, is_signed)};
`else
                    prod   <= '0;
`endif
                end else begin
                    opnd   <= mag(a_r, is_signed);
                    prod   <= {{XLEN{1'b0}}, mag(b_r, is_signed)};
                    neg_lo <= is_signed & (a_r[XLEN-1] ^ b_r[XLEN-1]);
                end
            end
            if (step) begin
                if (is_div) begin
`ifdef MDU_DIV_EN
                    if (sub_diff[XLEN]) begin
                        prod <= {prod[2*XLEN-2:0], 1'b0};
                    end else begin
                        prod <= {sub_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
                    end
`endif
                end else if (prod[0]) begin
                    prod <= {add_sum, prod[XLEN-1:1]};
                end else begin
                    prod <= {1'b0, prod[2*XLEN-1:1]};
                end
            end
            if (fix) begin
                prod <= fix_val;
            end
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multicycle multiply/divide sequencer: FSM, iteration counter and register-file write port.
// Define MDU_DIV_EN to build the divide path and div_zero flag.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// PREP  | magnitudes and result signs latched
// ITER  | XLEN shift-add or restoring-divide steps
// FIX   | sign fix-up and accumulate
// WB_LO | write lo word / quotient to rd_lo
// WB_HI | write hi word / remainder to rd_hi (long only)
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN,
    parameter int RAW  = MDU_RAW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              is_long,
    input  logic              is_signed,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    input  logic [2*XLEN-1:0] acc,
    input  logic [RAW-1:0]    rd_lo,
    input  logic [RAW-1:0]    rd_hi,
    output logic              stall,
    output logic              busy,
    output logic              we,
    output logic [RAW-1:0]    wa,
    output logic [XLEN-1:0]   wd,
    output logic              done,
    output logic              div_zero
);

    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    state_t          state;
    logic [CW-1:0]   count;
    logic [1:0]      op_q;
    logic            long_q;
    logic            signed_q;
    logic [RAW-1:0]  rd_lo_q;
    logic [RAW-1:0]  rd_hi_q;
    logic [XLEN-1:0] fix_lo;
    logic [XLEN-1:0] res_hi;
    logic            is_div;
    logic            is_mla;
    logic            capture;

    assign busy    = (state != IDLE);
    assign stall   = start | busy;
    assign is_div  = (op_q == MDU_DIV);
    assign is_mla  = (op_q == MDU_MLA);
    assign capture = (state == IDLE) & start;

`ifdef MDU_DIV_EN
    logic b_zero;
    logic dz_q;
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    mdu_datapath #(.XLEN(XLEN)) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .load      (state == PREP),
        .step      (state == ITER),
        .fix       (state == FIX),
        .is_div    (is_div),
        .is_mla    (is_mla),
        .is_long   (long_q),
        .is_signed (signed_q),
        .opa       (opa),
        .opb       (opb),
        .acc       (acc),
`ifdef MDU_DIV_EN
        .b_zero    (b_zero),
`endif
        .fix_lo    (fix_lo),
        .res_hi    (res_hi)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            we       <= 1'b0;
            done     <= 1'b0;
            wa       <= '0;
            wd       <= '0;
            op_q     <= MDU_MUL;
            long_q   <= 1'b0;
            signed_q <= 1'b0;
            rd_lo_q  <= '0;
            rd_hi_q  <= '0;
`ifdef MDU_DIV_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        signed_q <= is_signed;
                        rd_lo_q  <= rd_lo;
                        rd_hi_q  <= rd_hi;
`ifdef MDU_DIV_EN
                        long_q   <= is_long;
                        dz_q     <= 1'b0;
`else
                        // Without a divider, op=DIV only ever writes rd_lo.
                        long_q   <= is_long & (op != MDU_DIV);
`endif
                        state    <= PREP;
                    end
                end
                PREP: begin
                    count <= '0;
                    state <= ITER;
                    if (is_div) begin
`ifdef MDU_DIV_EN
                        if (b_zero) begin
                            dz_q  <= 1'b1;
                            state <= WB_LO;
                            we    <= 1'b1;
                            wa    <= rd_lo_q;
                            wd    <= {XLEN{1'b1}};
                            done  <= ~long_q;
                        end
`else
                        state <= WB_LO;
                        we    <= 1'b1;
                        wa    <= rd_lo_q;
                        wd    <= '0;
                        done  <= 1'b1;
`endif
                    end
                end
                ITER: begin
                    count <= count + 1'b1;
                    if (count == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= WB_LO;
                    we    <= 1'b1;
                    wa    <= rd_lo_q;
                    wd    <= fix_lo;
                    done  <= ~long_q;
                end
                WB_LO: begin
                    if (long_q) begin
                        state <= WB_HI;
                        we    <= 1'b1;
                        wa    <= rd_hi_q;
                        wd    <= res_hi;
                        done  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WB_HI: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
